// File: rtl/mixffn_pkg.sv
// Shared constants and types for the MixFFN depthwise-conv parameter path.
// Load word counts are derived from the channel and tap geometry.
package mixffn_pkg;

   localparam int CHANNELS    = 256;
   localparam int K_TAPS      = 9;
   localparam int DW          = 16;

   localparam int W_WORDS     = CHANNELS * K_TAPS;
   localparam int B_WORDS     = CHANNELS;
   localparam int TOTAL_WORDS = W_WORDS + B_WORDS;

   localparam int CH_W        = $clog2(CHANNELS);
   localparam int TAP_W       = $clog2(K_TAPS);
   localparam int WC_W        = $clog2(TOTAL_WORDS);
   localparam int PK_W        = K_TAPS * DW;

   typedef enum logic [1:0] {
      S_LOAD_W,
      S_LOAD_B,
      S_READY
   } feeder_state_t;

endpackage

// File: rtl/param_sp_ram.sv
// Single-port RAM with synchronous read; contents are not reset.
// One address serves both the load writes and the streaming reads.
module param_sp_ram #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic             re,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[addr] <= wdata;
      if (re)
         rdata <= mem[addr];
   end

endmodule

// File: rtl/dwconv_param_feeder.sv
// Depthwise-conv kernel/bias feeder: word-serial bulk load, then one
// channel's taps and bias per request, wrapping over all channels.
module dwconv_param_feeder
   import mixffn_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load_start,
   input  logic            load_valid,
   input  logic [DW-1:0]   load_data,
   output logic            load_ready,
   output logic            loaded,
   input  logic            req_valid,
   output logic            in_valid_dwconv,
   output logic [PK_W-1:0] weight_conv,
   output logic [DW-1:0]   bias,
   output logic [CH_W-1:0] ch_idx,
   output logic            req_err
);

   feeder_state_t   state;
   logic [WC_W-1:0] word_cnt;
   logic [TAP_W-1:0] tap_cnt;
   logic [CH_W-1:0] wr_ch;
   logic [CH_W-1:0] ch_cnt;
   logic [CH_W-1:0] rd_ch;
   logic            rd_v;
   logic [PK_W-1:0] packer;
   logic [PK_W-1:0] w_wdata;
   logic [PK_W-1:0] w_rdata;
   logic [DW-1:0]   b_rdata;
   logic            accept;
   logic            last_tap;
   logic            w_we;
   logic            b_we;
   logic            rd_en;
   logic [CH_W-1:0] mem_addr;
   logic [CH_W-1:0] ch_nxt;

   assign accept   = load_valid && load_ready && !load_start;
   assign last_tap = (tap_cnt == TAP_W'(K_TAPS - 1));
   // Newest word enters at the top, so tap 0 ends up at the bottom.
   assign w_wdata  = {load_data, packer[PK_W-1:DW]};
   assign w_we     = accept && (state == S_LOAD_W) && last_tap;
   assign b_we     = accept && (state == S_LOAD_B);
   assign rd_en    = req_valid && (state == S_READY) && !load_start;
   assign mem_addr = (state == S_READY) ? ch_cnt : wr_ch;
   assign ch_nxt   = (ch_cnt == CH_W'(CHANNELS - 1)) ?
                     '0 : ch_cnt + CH_W'(1);

   param_sp_ram #(
      .WIDTH (PK_W),
      .DEPTH (CHANNELS)
   ) u_wmem (
      .clk   (clk),
      .we    (w_we),
      .re    (rd_en),
      .addr  (mem_addr),
      .wdata (w_wdata),
      .rdata (w_rdata)
   );

   param_sp_ram #(
      .WIDTH (DW),
      .DEPTH (CHANNELS)
   ) u_bmem (
      .clk   (clk),
      .we    (b_we),
      .re    (rd_en),
      .addr  (mem_addr),
      .wdata (load_data),
      .rdata (b_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_LOAD_W;
         word_cnt        <= '0;
         tap_cnt         <= '0;
         wr_ch           <= '0;
         ch_cnt          <= '0;
         rd_ch           <= '0;
         rd_v            <= 1'b0;
         packer          <= '0;
         load_ready      <= 1'b1;
         loaded          <= 1'b0;
         req_err         <= 1'b0;
         in_valid_dwconv <= 1'b0;
         weight_conv     <= '0;
         bias            <= '0;
         ch_idx          <= '0;
      end else begin
         in_valid_dwconv <= 1'b0;
         rd_v            <= 1'b0;
         if (load_start) begin
            // Also kills any read still in flight.
            state      <= S_LOAD_W;
            word_cnt   <= '0;
            tap_cnt    <= '0;
            wr_ch      <= '0;
            ch_cnt     <= '0;
            load_ready <= 1'b1;
            loaded     <= 1'b0;
            req_err    <= 1'b0;
         end else begin
            unique case (state)
               S_LOAD_W: begin
                  if (req_valid)
                     req_err <= 1'b1;
                  if (accept) begin
                     packer   <= w_wdata;
                     word_cnt <= word_cnt + WC_W'(1);
                     if (last_tap) begin
                        tap_cnt <= '0;
                        wr_ch   <= wr_ch + CH_W'(1);
                        if (word_cnt == WC_W'(W_WORDS - 1)) begin
                           state <= S_LOAD_B;
                           wr_ch <= '0;
                        end
                     end else begin
                        tap_cnt <= tap_cnt + TAP_W'(1);
                     end
                  end
               end
               S_LOAD_B: begin
                  if (req_valid)
                     req_err <= 1'b1;
                  if (accept) begin
                     word_cnt <= word_cnt + WC_W'(1);
                     wr_ch    <= wr_ch + CH_W'(1);
                     if (word_cnt == WC_W'(TOTAL_WORDS - 1)) begin
                        state      <= S_READY;
                        wr_ch      <= '0;
                        loaded     <= 1'b1;
                        load_ready <= 1'b0;
                     end
                  end
               end
               S_READY: begin
                  if (rd_en) begin
                     rd_v   <= 1'b1;
                     rd_ch  <= ch_cnt;
                     ch_cnt <= ch_nxt;
                  end
               end
               default: begin
                  state <= S_LOAD_W;
               end
            endcase
            if (rd_v) begin
               in_valid_dwconv <= 1'b1;
               weight_conv     <= w_rdata;
               bias            <= b_rdata;
               ch_idx          <= rd_ch;
            end
         end
      end
   end

endmodule
